bit_serializer_msb: RTL and testbench
=====================================

Name: bit_serializer_msb

Overview:
- Upstream stage of the serial pattern detector. Accepts parallel words over a valid/ready handshake and shifts each word out MSB first, one bit per clk.
- ser_out connects directly to the detector's serial input (PI).
- ser_valid marks the bits that belong to a frame.
- frame_done flags the final bit so downstream logic can align detections to word boundaries.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH+1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately).
- din  input  WIDTH  parallel word to serialize.
- din_valid  input  1  source has a word on din.
- din_ready  output  1  serializer can take a word this cycle.
- ser_out  output  1  serial data bit (registered); drives detector PI.
- ser_valid  output  1  ser_out carries a frame bit this cycle (registered).
- frame_done  output  1  high during the last bit of a frame.
- busy  output  1  high while in SHIFT.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; shift register, bit counter, ser_out, ser_valid all 0.
  - Combinational outputs are then: din_ready=1, frame_done=0, busy=0.
- Transfer rule: a word is accepted at a rising edge where din_valid=1 and din_ready=1. There is no other path into the shift register.
- IDLE state:
  - din_ready=1, ser_out=0, ser_valid=0.
  - On accept: shreg<=din, cnt<=0, ser_valid<=1, state<=SHIFT.
- SHIFT state:
  - ser_out=shreg[WIDTH-1], busy=1.
  - Each edge while not on the last bit: shreg<=shreg<<1 (zero fill), cnt<=cnt+1.
- Last bit (cnt==LAST, where LAST=WIDTH-1):
  - frame_done=1 and din_ready=1, both combinational from state/cnt.
  - At that edge, on accept: reload shreg<=din, cnt<=0, stay in SHIFT. This gives back-to-back frames with no idle bit.
  - Otherwise: state<=IDLE, ser_out<=0, ser_valid<=0.
- In SHIFT, on any bit other than the last: din_ready=0; din/din_valid are ignored and the source must hold.
- Latency: a word accepted at edge k has its MSB on ser_out after edge k. Bit i (MSB=0) is on ser_out during cycle k+1+i, so the detector samples it at edge k+2+i.
- Frame length: exactly WIDTH consecutive ser_valid cycles per word.
- Counter: cnt never exceeds LAST; no wrap-around.
- Idle line: ser_out is 0 whenever ser_valid=0, so an idle gap never forms a spurious 1 on the detector input.
- Reset asserted mid-frame: the frame is aborted immediately and the remaining bits are lost. After reset releases, the first accept starts a fresh frame from its MSB.
- din_valid=1 during reset is ignored. The first possible accept is the first rising edge with reset=1.

Optional Feature:
- Macro: SER_PARITY_EN.
- When defined:
  - One even-parity bit (XOR of the accepted word, latched at accept) is appended after the LSB. Frame length becomes WIDTH+1.
  - LAST=WIDTH. frame_done and din_ready are asserted on the parity bit, not the LSB.
  - Back-to-back reload then occurs on the parity-bit edge.
- When undefined: no parity logic is present, frame length is WIDTH, LAST=WIDTH-1.

Test Plan:
- Reset then single word: reset low 3 cycles, release, din=8'hB0 with din_valid pulsed 1 cycle -> ser_out 1,0,1,1,0,0,0,0 over 8 consecutive cycles with ser_valid=1. frame_done high only on the 8th. Then ser_out=0, ser_valid=0, din_ready=1.
- Back-to-back: 8'hB0 then 8'hD0 presented on the last bit of the first frame -> 16 contiguous ser_valid cycles: 10110000 11010000. No gap; frame_done pulses twice, 8 cycles apart.
- Backpressure: din_valid held high with 8'hFF from cycle 2 of an active 8'h0F frame -> din_ready=0 until the last bit of 8'h0F. 8'hFF starts on the very next cycle. 8'h0F is shifted out unchanged (00001111).
- Mid-frame reset: reset pulled low during bit 3 of 8'hB0 -> ser_out, ser_valid, busy go 0 immediately. After release, 8'hA5 serializes as 10100101 from its MSB.
- Detector integration: serializer ser_out to detector PI with 8'b10110000 -> detector PO=1 in the cycle ser_out carries bit 3 (the final 1 of 1011), and nowhere else in the frame.
- SER_PARITY_EN build: din=8'hB0 (three 1s) -> 9 bits 101100001. frame_done only on the 9th. din=8'h33 -> parity bit 0.

Source files
------------

// File: rtl/bit_serializer_msb.sv
// bit_serializer_msb
//   Takes parallel words over a valid/ready handshake and shifts each one out
//   MSB first, one bit per clk, to feed the serial pattern detector.
//
//   Optional build macro: SER_PARITY_EN
//     When defined, an even-parity bit (XOR of the accepted word) follows the
//     LSB, making each frame WIDTH+1 bits long.
//
//   Ports
//     clk        in   system clock, rising edge
//     reset      in   asynchronous active-low reset
//     din        in   [WIDTH-1:0] parallel word
//     din_valid  in   source has a word on din
//     din_ready  out  word accepted at this edge if din_valid is high
//     ser_out    out  serial bit, straight from a flop
//     ser_valid  out  ser_out carries a frame bit (registered)
//     frame_done out  last bit of the frame is on ser_out
//     busy       out  shifting a frame
module bit_serializer_msb #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SW - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             sv_q,    sv_d;
  logic             last_bit;
  logic             accept;
  logic [SW-1:0]    load_word;

  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);
  assign accept   = din_valid && din_ready;

  // Parity rides in the shift register below the LSB, so the plain MSB-first
  // shift emits it right after the data bits.
`ifdef SER_PARITY_EN
  assign load_word = {din, ^din};
`else
  assign load_word = din;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_bit && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state/count
  always_comb begin
    din_ready  = (state_q == IDLE) || last_bit;
    frame_done = last_bit;
    busy       = (state_q == SHIFT);
  end

  // Datapath next state. Reload on the last bit gives back-to-back frames;
  // leaving SHIFT clears shreg so ser_out idles at 0.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sv_d    = sv_q;
    if (accept) begin
      shreg_d = load_word;
      cnt_d   = '0;
      sv_d    = 1'b1;
    end else if (state_q == SHIFT) begin
      if (last_bit) begin
        shreg_d = '0;
        cnt_d   = '0;
        sv_d    = 1'b0;
      end else begin
        shreg_d = shreg_q << 1;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      sv_q    <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sv_q    <= sv_d;
    end
  end

  assign ser_out   = shreg_q[SW-1];
  assign ser_valid = sv_q;

endmodule

// File: tb/tb_bit_serializer_msb.sv
module tb_bit_serializer_msb;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         din_ready, ser_out, ser_valid, frame_done, busy;

  bit_serializer_msb #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: queue of bits still to appear on the line, head = now.
  bit q[$];
  bit acc_last;
  int cyc = 0;

  // Collectors for hand sequences
  logic [63:0] stream;
  int          slen, fdc, fd_first, fd_last;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit acc;
    acc_last = 1'b0;
    if (!reset) begin
      q.delete();
    end else begin
      acc = din_valid && (q.size() <= 1);
      if (q.size() > 0) void'(q.pop_front());
      if (acc) begin
        for (int i = W - 1; i >= 0; i--) q.push_back(din[i]);
`ifdef SER_PARITY_EN
        q.push_back(^din);
`endif
        acc_last = 1'b1;
      end
    end
  endtask

  task automatic chk_model();
    chk("ser_out",    ser_out,    (q.size() > 0) ? q[0] : 1'b0);
    chk("ser_valid",  ser_valid,  q.size() > 0);
    chk("frame_done", frame_done, q.size() == 1);
    chk("din_ready",  din_ready,  q.size() <= 1);
    chk("busy",       busy,       q.size() > 0);
  endtask

  task automatic clr_col();
    stream = '0; slen = 0; fdc = 0; fd_first = -1; fd_last = -1;
  endtask

  // One clock: model advances at the rising edge, outputs sampled and
  // collected at the falling edge. Inputs are changed by the caller afterwards.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    if (ser_valid) begin stream = {stream[62:0], ser_out}; slen++; end
    if (frame_done) begin
      fdc++;
      if (fd_first < 0) fd_first = cyc;
      fd_last = cyc;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (ser_valid && n < 40) begin step(); chk_model(); n++; end
    if (n >= 40) chk("drain_timeout", 1, 0);
  endtask

  typedef struct {
    logic         rst, vld;
    logic [W-1:0] d;
    logic         so, sv, fd, rdy, bsy;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic vld, logic [W-1:0] d,
                              logic so, logic sv, logic fd, logic rdy, logic bsy);
    vec_t v;
    v.rst = rst; v.vld = vld; v.d = d;
    v.so = so; v.sv = sv; v.fd = fd; v.rdy = rdy; v.bsy = bsy;
    return v;
  endfunction

  initial begin
    // Reset, then one B0 word pulsed for a single cycle.
    tbl.push_back(mk(0, 1, 8'hB0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 8'hB0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 8'hB0, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 1));
`ifdef SER_PARITY_EN
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'h00, 1, 1, 1, 1, 1));
`else
    tbl.push_back(mk(1, 0, 8'h00, 0, 1, 1, 1, 1));
`endif
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 1, 0));

    @(negedge clk);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_din_ready", din_ready, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; din_valid = tbl[i].vld; din = tbl[i].d;
      step();
      chk($sformatf("tbl%0d_ser_out", i),    ser_out,    tbl[i].so);
      chk($sformatf("tbl%0d_ser_valid", i),  ser_valid,  tbl[i].sv);
      chk($sformatf("tbl%0d_frame_done", i), frame_done, tbl[i].fd);
      chk($sformatf("tbl%0d_din_ready", i),  din_ready,  tbl[i].rdy);
      chk($sformatf("tbl%0d_busy", i),       busy,       tbl[i].bsy);
    end
    din_valid = 0;

    // Back-to-back: D0 offered on the last bit of B0.
    begin
      int n = 0;
      clr_col();
      din = 8'hB0; din_valid = 1; step(); chk_model(); din_valid = 0;
      while (!din_ready && n < 20) begin step(); chk_model(); n++; end
      if (n >= 20) chk("b2b_ready_timeout", 1, 0);
      din = 8'hD0; din_valid = 1; step(); chk_model(); din_valid = 0;
      drain();
`ifdef SER_PARITY_EN
      chk("b2b_stream", stream, {46'd0, 8'hB0, 1'b1, 8'hD0, 1'b1});
`else
      chk("b2b_stream", stream, {48'd0, 8'hB0, 8'hD0});
`endif
      chk("b2b_len", slen, 2 * FL);
      chk("b2b_fd_count", fdc, 2);
      chk("b2b_fd_spacing", fd_last - fd_first, FL);
    end

    // Backpressure: FF held valid from bit 1 of an active 0F frame.
    begin
      int n = 0;
      clr_col();
      din = 8'h0F; din_valid = 1; step(); chk_model();
      din = 8'hFF; din_valid = 1;
      acc_last = 0;
      while (!acc_last && n < 20) begin step(); chk_model(); n++; end
      if (n >= 20) chk("bp_accept_timeout", 1, 0);
      din_valid = 0;
      drain();
`ifdef SER_PARITY_EN
      chk("bp_stream", stream, {46'd0, 8'h0F, 1'b0, 8'hFF, 1'b0});
`else
      chk("bp_stream", stream, {48'd0, 8'h0F, 8'hFF});
`endif
      chk("bp_len", slen, 2 * FL);
    end

    // Mid-frame reset during bit 3 of B0, then A5 from its MSB.
    din = 8'hB0; din_valid = 1; step(); chk_model(); din_valid = 0;
    for (int i = 0; i < 3; i++) begin step(); chk_model(); end
    chk("mid_bit3", ser_out, 1);
    reset = 0;
    #1;
    q.delete();
    chk("mid_rst_ser_out", ser_out, 0);
    chk("mid_rst_ser_valid", ser_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_din_ready", din_ready, 1);
    @(negedge clk);
    reset = 1;
    clr_col();
    din = 8'hA5; din_valid = 1; step(); chk_model(); din_valid = 0;
    drain();
`ifdef SER_PARITY_EN
    chk("mid_a5_stream", stream, {55'd0, 8'hA5, 1'b0});
`else
    chk("mid_a5_stream", stream, {56'd0, 8'hA5});
`endif
    chk("mid_a5_len", slen, FL);

    // Randomized traffic with occasional resets against the queue model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        reset = 0;
        #1;
        q.delete();
        chk_model();
      end else begin
        reset = 1;
      end
      // Source holds its word while it is offered but not yet taken.
      if (!(din_valid && q.size() > 1)) begin
        din_valid = ($urandom_range(0, 3) != 0);
        din = W'($urandom);
      end
      step();
      chk_model();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
